amm_mem_responder: RTL and testbench

Avalon-MM slave responder that terminates the memory-checker's Avalon-MM master port in simulation and FPGA loopback builds. Provides a word-addressed on-chip memory with burst reads and writes, fixed read latency, up to CMD_DEPTH outstanding read bursts, and optional pseudo-random waitrequest insertion, so the measurement path sees realistic latency and back-pressure.

---
 rtl/amm_mem_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_amm_mem_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_mem_responder.sv
// Avalon-MM memory responder: burst reads/writes, fixed read latency,
// bounded outstanding reads and optional pseudo-random back-pressure.
module amm_mem_responder #(
    parameter int          ADDR_W      = 31,
    parameter int          DATA_W      = 64,
    parameter int          AMM_BURST_W = 11,
    parameter int          MEM_AW      = 10,
    parameter int          RD_LATENCY  = 4,
    parameter int          CMD_DEPTH   = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        address_i,
    input  logic                     read_i,
    input  logic                     write_i,
    input  logic [DATA_W-1:0]        writedata_i,
    input  logic [DATA_W/8-1:0]      byteenable_i,
    input  logic [AMM_BURST_W-1:0]   burstcount_i,
    output logic                     waitrequest_o,
    output logic [DATA_W-1:0]        readdata_o,
    output logic                     readdatavalid_o,
    input  logic                     stall_en_i,
    output logic                     protocol_err_o
);

    localparam int DATA_B_W = DATA_W / 8;
    localparam int DEPTH    = 2 ** MEM_AW;
    localparam int DL       = RD_LATENCY - 2;
    localparam int PW       = $clog2(CMD_DEPTH);
    localparam int CW       = PW + 1;
    localparam int OW       = $clog2(CMD_DEPTH + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        WR_IDLE,
        WR_BURST
    } wr_state_t;

    typedef struct packed {
        logic [MEM_AW-1:0]      addr;
        logic [AMM_BURST_W-1:0] bc;
    } rd_cmd_t;

    logic [DATA_W-1:0]      mem [DEPTH];

    wr_state_t              wr_state;
    logic [MEM_AW-1:0]      wr_addr_q;
    logic [AMM_BURST_W-1:0] wr_rem_q;

    logic                   init_q;
    logic                   stall_q;
    logic [15:0]            lfsr_q;
    logic [OW-1:0]          out_cnt_q;

    rd_cmd_t                fifo_q [CMD_DEPTH];
    logic [PW-1:0]          wp_q;
    logic [PW-1:0]          rp_q;
    logic [CW-1:0]          fcnt_q;

    logic                   svc_q;
    logic [MEM_AW-1:0]      svc_addr_q;
    logic [AMM_BURST_W-1:0] svc_rem_q;
    logic                   last_q;

    logic                   full;
    logic                   cmd_zero;
    logic                   acc_wr;
    logic                   acc_rd;
    logic                   rd_go;
    logic                   wr_first;
    logic                   wr_go;
    logic                   proto_hit;
    logic [MEM_AW-1:0]      wr_addr;
    rd_cmd_t                rd_in;
    rd_cmd_t                dl_out;
    logic                   dl_out_v;
    rd_cmd_t                head;
    logic                   pop;
    logic                   unused_hi;

    assign unused_hi = ^address_i[ADDR_W-1:MEM_AW];

    assign full          = (out_cnt_q == OW'(CMD_DEPTH));
    assign waitrequest_o = init_q || stall_q || full;

    assign cmd_zero = (burstcount_i == '0);
    assign acc_wr   = write_i && !waitrequest_o;
    assign acc_rd   = read_i && !write_i && !waitrequest_o
                      && (wr_state == WR_IDLE);
    assign rd_go    = acc_rd && !cmd_zero;
    assign wr_first = acc_wr && (wr_state == WR_IDLE);
    assign wr_go    = acc_wr && !(wr_first && cmd_zero);
    assign wr_addr  = (wr_state == WR_IDLE) ? address_i[MEM_AW-1:0]
                                            : wr_addr_q;

    assign proto_hit = (acc_rd && cmd_zero)
                     || (wr_first && cmd_zero)
                     || (read_i && (wr_state == WR_BURST))
                     || (read_i && write_i);

    assign rd_in = '{addr: address_i[MEM_AW-1:0], bc: burstcount_i};
    assign head  = fifo_q[rp_q];
    assign pop   = !svc_q && (fcnt_q != '0);

    // Byte-lane masked write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wr_go) begin
            for (int b = 0; b < DATA_B_W; b++) begin
                if (byteenable_i[b]) begin
                    mem[wr_addr][8*b +: 8] <= writedata_i[8*b +: 8];
                end
            end
        end
    end

    // Write burst tracker: base address and beats still expected
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state  <= WR_IDLE;
            wr_addr_q <= '0;
            wr_rem_q  <= '0;
        end else if (acc_wr) begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (!cmd_zero) begin
                        wr_addr_q <= address_i[MEM_AW-1:0] + MEM_AW'(1);
                        wr_rem_q  <= burstcount_i - AMM_BURST_W'(1);
                        if (burstcount_i != AMM_BURST_W'(1)) begin
                            wr_state <= WR_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    wr_addr_q <= wr_addr_q + MEM_AW'(1);
                    wr_rem_q  <= wr_rem_q - AMM_BURST_W'(1);
                    if (wr_rem_q == AMM_BURST_W'(1)) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Stall LFSR, registered stall bit and post-reset hold-off
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q  <= LFSR_SEED;
            stall_q <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            lfsr_q  <= {1'b0, lfsr_q[15:1]}
                       ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
            stall_q <= stall_en_i && lfsr_q[0];
            init_q  <= 1'b0;
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            protocol_err_o <= 1'b0;
        end else if (proto_hit) begin
            protocol_err_o <= 1'b1;
        end
    end

    // Outstanding bursts: retire once the last beat has been presented
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_q + OW'(rd_go) - OW'(last_q);
        end
    end

    generate
        if (DL == 0) begin : g_nodl
            assign dl_out_v = rd_go;
            assign dl_out   = rd_in;
        end else begin : g_dl
            logic [DL-1:0] v_q;
            rd_cmd_t       c_q [DL];

            assign dl_out_v = v_q[DL-1];
            assign dl_out   = c_q[DL-1];

            // Fixed delay line that sets the read latency
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    v_q <= '0;
                    for (int i = 0; i < DL; i++) begin
                        c_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= rd_go;
                    c_q[0] <= rd_in;
                    for (int i = 1; i < DL; i++) begin
                        v_q[i] <= v_q[i-1];
                        c_q[i] <= c_q[i-1];
                    end
                end
            end
        end
    endgenerate

    // Command FIFO storage, no reset needed behind valid pointers
    always_ff @(posedge clk_i) begin
        if (dl_out_v) begin
            fifo_q[wp_q] <= dl_out;
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (dl_out_v) begin
                wp_q <= wp_q + PW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PW'(1);
            end
            fcnt_q <= fcnt_q + CW'(dl_out_v) - CW'(pop);
        end
    end

    // Read engine: one beat per cycle, next burst follows without gap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            svc_q           <= 1'b0;
            svc_addr_q      <= '0;
            svc_rem_q       <= '0;
            last_q          <= 1'b0;
            readdatavalid_o <= 1'b0;
            readdata_o      <= '0;
        end else begin
            readdatavalid_o <= 1'b0;
            last_q          <= 1'b0;
            if (svc_q) begin
                readdata_o      <= mem[svc_addr_q];
                readdatavalid_o <= 1'b1;
                svc_addr_q      <= svc_addr_q + MEM_AW'(1);
                svc_rem_q       <= svc_rem_q - AMM_BURST_W'(1);
                if (svc_rem_q == AMM_BURST_W'(1)) begin
                    svc_q  <= 1'b0;
                    last_q <= 1'b1;
                end
            end else if (pop) begin
                readdata_o      <= mem[head.addr];
                readdatavalid_o <= 1'b1;
                svc_addr_q      <= head.addr + MEM_AW'(1);
                svc_rem_q       <= head.bc - AMM_BURST_W'(1);
                svc_q           <= (head.bc != AMM_BURST_W'(1));
                last_q          <= (head.bc == AMM_BURST_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_amm_mem_responder.sv
// Directed bench for amm_mem_responder: bursts, byte enables, full
// back-pressure, random stalls, protocol errors, wrap and reset.
module tb_amm_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [30:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] writedata_i;
    logic [7:0]  byteenable_i;
    logic [10:0] burstcount_i;
    logic        waitrequest_o;
    logic [63:0] readdata_o;
    logic        readdatavalid_o;
    logic        stall_en_i;
    logic        protocol_err_o;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [63:0] rq[$];
    int          rc[$];
    bit          meas   = 0;
    int          wcnt   = 0;
    int          tot    = 0;
    logic [63:0] model [1024];
    int          wl [1000];

    amm_mem_responder dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .address_i       (address_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .writedata_i     (writedata_i),
        .byteenable_i    (byteenable_i),
        .burstcount_i    (burstcount_i),
        .waitrequest_o   (waitrequest_o),
        .readdata_o      (readdata_o),
        .readdatavalid_o (readdatavalid_o),
        .stall_en_i      (stall_en_i),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (readdatavalid_o) begin
            rq.push_back(readdata_o);
            rc.push_back(cyc);
        end
        if (meas) begin
            tot++;
            if (waitrequest_o) wcnt++;
        end
    end

    task automatic wait_accept(output int t);
        bit ok;
        bit w;
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            w = waitrequest_o;
            @(posedge clk_i);
            #1;
            if (!w) ok = 1;
            n++;
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL accept_timeout: waitrequest stuck at 1, want 0");
        end
        t = cyc;
    endtask

    task automatic wr(input logic [30:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [10:0] bc);
        int t;
        write_i      = 1;
        address_i    = a;
        writedata_i  = d;
        byteenable_i = be;
        burstcount_i = bc;
        wait_accept(t);
        write_i = 0;
    endtask

    task automatic rd(input logic [30:0] a, input logic [10:0] bc,
                      output int t);
        read_i       = 1;
        address_i    = a;
        burstcount_i = bc;
        wait_accept(t);
        read_i = 0;
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (rq.size() < n && k < 300) begin
            @(posedge clk_i);
            #1;
            k++;
        end
    endtask

    task automatic rst_pulse();
        rst_i = 1;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_chk++;
        if (waitrequest_o !== 1'b1) $display("FAIL rst_wait: got %b want 1", waitrequest_o);
        else n_pass++;
        n_chk++;
        if (readdatavalid_o !== 1'b0) $display("FAIL rst_rdv: got %b want 0", readdatavalid_o);
        else n_pass++;
        n_chk++;
        if (readdata_o !== 64'h0) $display("FAIL rst_rdata: got %h want 0", readdata_o);
        else n_pass++;
        n_chk++;
        if (protocol_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", protocol_err_o);
        else n_pass++;
        rst_i = 0;
        #1;
        n_chk++;
        if (waitrequest_o !== 1'b1) $display("FAIL rst_hold: got %b want 1", waitrequest_o);
        else n_pass++;
        @(posedge clk_i);
        #1;
        n_chk++;
        if (waitrequest_o !== 1'b0) $display("FAIL rst_release: got %b want 0", waitrequest_o);
        else n_pass++;
    endtask

    task automatic test_burst_rw();
        int t;
        for (int i = 0; i < 4; i++) wr(31'h10, 64'(i + 1), 8'hFF, 11'd4);
        rq.delete();
        rc.delete();
        rd(31'h10, 11'd4, t);
        wait_beats(4);
        n_chk++;
        if (rq.size() !== 4) $display("FAIL burst_cnt: got %0d want 4", rq.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rq[i] !== 64'(i + 1)) $display("FAIL burst_data%0d: got %h want %h", i, rq[i], 64'(i + 1));
            else n_pass++;
            n_chk++;
            if (rc[i] !== t + 3 + i) $display("FAIL burst_time%0d: got %0d want %0d", i, rc[i], t + 3 + i);
            else n_pass++;
        end
    endtask

    task automatic test_byteenable();
        int t;
        wr(31'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 11'd1);
        wr(31'h20, 64'h0, 8'h0F, 11'd1);
        rq.delete();
        rc.delete();
        rd(31'h20, 11'd1, t);
        wait_beats(1);
        n_chk++;
        if (rq[0] !== 64'hFFFF_FFFF_0000_0000) $display("FAIL byteen: got %h want ffffffff00000000", rq[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t [5];
        for (int i = 0; i < 40; i++) wr(31'h100, 64'h1000 + 64'(i), 8'hFF, 11'd40);
        rq.delete();
        rc.delete();
        for (int i = 0; i < 5; i++) rd(31'h100 + 31'(8 * i), 11'd8, t[i]);
        wait_beats(40);
        n_chk++;
        if (t[3] - t[0] !== 3) $display("FAIL b2b_acc4: got %0d want 3", t[3] - t[0]);
        else n_pass++;
        n_chk++;
        if (t[4] - t[0] !== 12) $display("FAIL b2b_acc5: got %0d want 12", t[4] - t[0]);
        else n_pass++;
        n_chk++;
        if (rq.size() !== 40) $display("FAIL b2b_cnt: got %0d want 40", rq.size());
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            n_chk++;
            if (rq[i] !== 64'h1000 + 64'(i)) $display("FAIL b2b_data%0d: got %h want %h", i, rq[i], 64'h1000 + 64'(i));
            else n_pass++;
            n_chk++;
            if (rc[i] !== t[0] + 3 + i) $display("FAIL b2b_time%0d: got %0d want %0d", i, rc[i], t[0] + 3 + i);
            else n_pass++;
        end
    endtask

    task automatic test_conflict();
        int t;
        rq.delete();
        rc.delete();
        read_i       = 1;
        write_i      = 1;
        address_i    = 31'h30;
        writedata_i  = 64'h5555_AAAA_1234_5678;
        byteenable_i = 8'hFF;
        burstcount_i = 11'd1;
        wait_accept(t);
        read_i  = 0;
        write_i = 0;
        n_chk++;
        if (protocol_err_o !== 1'b1) $display("FAIL conflict_err: got %b want 1", protocol_err_o);
        else n_pass++;
        repeat (8) @(posedge clk_i);
        #1;
        n_chk++;
        if (rq.size() !== 0) $display("FAIL conflict_noread: got %0d beats want 0", rq.size());
        else n_pass++;
        rd(31'h30, 11'd1, t);
        wait_beats(1);
        n_chk++;
        if (rq[0] !== 64'h5555_AAAA_1234_5678) $display("FAIL conflict_wr: got %h want 5555aaaa12345678", rq[0]);
        else n_pass++;
        rst_pulse();
        n_chk++;
        if (protocol_err_o !== 1'b0) $display("FAIL conflict_clr: got %b want 0", protocol_err_o);
        else n_pass++;
    endtask

    task automatic test_stall();
        int t;
        int a;
        logic [63:0] d;
        stall_en_i = 1;
        wcnt = 0;
        tot  = 0;
        meas = 1;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 1023));
            d = {$urandom, $urandom};
            wr(31'(a), d, 8'hFF, 11'd1);
            model[a] = d;
            wl[i] = a;
        end
        for (int i = 0; i < 1000; i++) begin
            a = wl[$urandom_range(0, 999)];
            rq.delete();
            rc.delete();
            rd(31'(a), 11'd1, t);
            wait_beats(1);
            n_chk++;
            if (rq[0] !== model[a]) $display("FAIL stall_data@%0d: got %h want %h", a, rq[0], model[a]);
            else n_pass++;
        end
        meas = 0;
        stall_en_i = 0;
        n_chk++;
        if (protocol_err_o !== 1'b0) $display("FAIL stall_err: got %b want 0", protocol_err_o);
        else n_pass++;
        n_chk++;
        if (wcnt * 100 < tot * 30 || wcnt * 100 > tot * 70)
            $display("FAIL stall_ratio: got %0d/%0d want 30..70 pct", wcnt, tot);
        else n_pass++;
    endtask

    task automatic test_bc_zero();
        int t;
        rq.delete();
        rc.delete();
        rd(31'h40, 11'd0, t);
        n_chk++;
        if (protocol_err_o !== 1'b1) $display("FAIL bc0_err: got %b want 1", protocol_err_o);
        else n_pass++;
        repeat (10) @(posedge clk_i);
        #1;
        n_chk++;
        if (rq.size() !== 0) $display("FAIL bc0_nodata: got %0d beats want 0", rq.size());
        else n_pass++;
        n_chk++;
        if (protocol_err_o !== 1'b1) $display("FAIL bc0_sticky: got %b want 1", protocol_err_o);
        else n_pass++;
        rst_pulse();
        n_chk++;
        if (protocol_err_o !== 1'b0) $display("FAIL bc0_clr: got %b want 0", protocol_err_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int t;
        for (int i = 0; i < 4; i++) wr(31'h07FE, 64'hA0 + 64'(i), 8'hFF, 11'd4);
        rq.delete();
        rc.delete();
        rd(31'h07FE, 11'd4, t);
        wait_beats(4);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rq[i] !== 64'hA0 + 64'(i)) $display("FAIL wrap_data%0d: got %h want %h", i, rq[i], 64'hA0 + 64'(i));
            else n_pass++;
        end
        rq.delete();
        rc.delete();
        rd(31'h0, 11'd1, t);
        wait_beats(1);
        n_chk++;
        if (rq[0] !== 64'hA2) $display("FAIL wrap_word0: got %h want a2", rq[0]);
        else n_pass++;
        rq.delete();
        rc.delete();
        rd(31'h03FE, 11'd4, t);
        repeat (6) @(negedge clk_i);
        n_chk++;
        if (readdatavalid_o !== 1'b1) $display("FAIL wrap_beat2: got %b want 1", readdatavalid_o);
        else n_pass++;
        #1;
        rst_i = 1;
        #1;
        n_chk++;
        if (readdatavalid_o !== 1'b0) $display("FAIL midrst_rdv: got %b want 0", readdatavalid_o);
        else n_pass++;
        n_chk++;
        if (waitrequest_o !== 1'b1) $display("FAIL midrst_wait: got %b want 1", waitrequest_o);
        else n_pass++;
        n_chk++;
        if (readdata_o !== 64'h0) $display("FAIL midrst_rdata: got %h want 0", readdata_o);
        else n_pass++;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        repeat (8) @(posedge clk_i);
        #1;
        n_chk++;
        if (rq.size() !== 3) $display("FAIL midrst_beats: got %0d want 3", rq.size());
        else n_pass++;
    endtask

    initial begin
        rst_i        = 1;
        read_i       = 0;
        write_i      = 0;
        address_i    = '0;
        writedata_i  = '0;
        byteenable_i = '0;
        burstcount_i = '0;
        stall_en_i   = 0;
        test_reset();
        test_burst_rw();
        test_byteenable();
        test_back_to_back();
        test_conflict();
        test_stall();
        test_bc_zero();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
